iir_inverse_serial: RTL and testbench



---
 rtl/iir_inv_pkg.sv | 27 ++
 rtl/iir_inv_mac.sv | 82 ++++++++
 rtl/iir_inverse_serial.sv | 194 +++++++++++++++++++
 tb/tb_iir_inverse_serial.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_inv_pkg.sv
// Shared sizes, state encoding and fixed-point constants for the inverse IIR equalizer.
package iir_inv_pkg;

    localparam int ORDER = 10;
    localparam int DW    = 32;
    localparam int CW    = 18;
    localparam int FRAC  = 16;
    localparam int ACCW  = 64;

    // Wide enough for the issue index, which runs 1 .. 2*ORDER+1
    localparam int IDXW = $clog2(2 * ORDER + 2);

    // Q1.16 unity gain
    localparam logic signed [CW-1:0] ONE = CW'(65536);

    // Output clamp limits, expressed at accumulator width
    localparam logic signed [ACCW-1:0] SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam logic signed [ACCW-1:0] SAT_MIN = -(64'sd1 <<< (DW - 1));

    typedef enum logic [1:0] {
        IDLE,
        MAC_NUM,
        MAC_DEN,
        OUT
    } state_t;

endpackage

// File: rtl/iir_inv_mac.sv
// Serial multiply-accumulate: registered signed product, 64-bit add/subtract
// accumulator, and the arithmetic-shift / clamp stage that forms x[n].
module iir_inv_mac
    import iir_inv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_clr,
    input  logic                 vld_p0,
    input  logic                 sub_p0,
    input  logic signed [DW-1:0] smp_p0,
    input  logic signed [CW-1:0] coef_p0,
    output logic signed [DW-1:0] res_data,
    output logic                 res_sat
);

    logic signed [DW+CW-1:0] prod_p1;
    logic                    sub_p1;
    logic                    vld_p1;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  acc_next;
    logic        [DW:0]      sat_word;

    // Drop Q1.16 fraction bits, then clamp to the sample range; MSB flags a clamp
    function automatic logic [DW:0] shift_sat(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_MAX)
            return {1'b1, SAT_MAX[DW-1:0]};
        else if (s < SAT_MIN)
            return {1'b1, SAT_MIN[DW-1:0]};
        else
            return {1'b0, s[DW-1:0]};
    endfunction

    // ---- stage p0 -> p1: product register ----
    // Control for the product stage follows the operand valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            sub_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            sub_p1 <= sub_p0;
        end
    end

    // Full-precision signed product, no truncation
    always_ff @(posedge clk) begin
        prod_p1 <= smp_p0 * coef_p0;
    end

    // ---- stage p1 -> accumulator ----
    // Next accumulator value; also feeds the output stage so the final tap is included
    always_comb begin
        acc_next = acc;
        if (vld_p1) begin
            if (sub_p1)
                acc_next = acc - ACCW'(prod_p1);
            else
                acc_next = acc + ACCW'(prod_p1);
        end
    end

    // Accumulator register, cleared when a new sample is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (acc_clr)
            acc <= '0;
        else
            acc <= acc_next;
    end

    // Shift and clamp of the running sum
    always_comb begin
        sat_word = shift_sat(acc_next);
        res_sat  = sat_word[DW];
        res_data = sat_word[DW-1:0];
    end

endmodule

// File: rtl/iir_inverse_serial.sv
// Time-multiplexed inverse IIR: x[n] = sat((sum a[k]y[n-k] - sum b[k]x[n-k]) >>> FRAC).
// Tap products are issued one cycle ahead of the accumulate, so tap 0 is issued
// straight from in_data in the accepting cycle.
module iir_inverse_serial
    import iir_inv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat,
    input  logic                 coef_we,
    input  logic                 coef_sel,
    input  logic        [3:0]    coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 clr
);

    state_t                 state, state_nxt;
    logic [IDXW-1:0]        idx;
    logic signed [DW-1:0]   y_lat;
    logic signed [DW-1:0]   y_hist [1:ORDER];
    logic signed [DW-1:0]   x_hist [1:ORDER];
    logic signed [CW-1:0]   a_coef [0:ORDER];
    logic signed [CW-1:0]   b_coef [1:ORDER];

    logic                   accept;
    logic                   coef_wr;
    logic                   hist_clr;
    logic                   load_out;
    logic                   iss_vld;
    logic                   iss_sub;
    logic signed [DW-1:0]   iss_smp;
    logic signed [CW-1:0]   iss_coef;
    logic signed [DW-1:0]   res_data;
    logic                   res_sat;

    assign accept   = (state == IDLE) && in_valid;
    assign coef_wr  = (state == IDLE) && coef_we;
    assign hist_clr = (state == IDLE) && clr;
    assign load_out = (state == MAC_DEN) && (idx == IDXW'(2 * ORDER + 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = MAC_NUM;
            end
            MAC_NUM: begin
                if (idx == IDXW'(ORDER + 1))
                    state_nxt = MAC_DEN;
            end
            MAC_DEN: begin
                if (idx == IDXW'(2 * ORDER + 1))
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue index: 1..ORDER numerator taps, ORDER+1..2*ORDER denominator taps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            idx <= '0;
        else if (state == IDLE)
            idx <= IDXW'(1);
        else if ((state == MAC_NUM) || (state == MAC_DEN))
            idx <= idx + IDXW'(1);
        else
            idx <= '0;
    end

    // Operand select; a same-cycle write to a[0] is forwarded to the tap-0 issue
    always_comb begin
        iss_vld  = 1'b0;
        iss_sub  = 1'b0;
        iss_smp  = in_data;
        iss_coef = a_coef[0];
        if (state == IDLE) begin
            iss_vld = in_valid;
            if (coef_wr && !coef_sel && (coef_addr == 4'd0))
                iss_coef = coef_data;
        end else if ((state == MAC_NUM) || (state == MAC_DEN)) begin
            for (int k = 1; k <= ORDER; k++) begin
                if (idx == IDXW'(k)) begin
                    iss_vld  = 1'b1;
                    iss_smp  = y_hist[k];
                    iss_coef = a_coef[k];
                end
                if (idx == IDXW'(k + ORDER)) begin
                    iss_vld  = 1'b1;
                    iss_sub  = 1'b1;
                    iss_smp  = x_hist[k];
                    iss_coef = b_coef[k];
                end
            end
        end
    end

    // Hold y[n] until it shifts into the history at the end of the sample
    always_ff @(posedge clk) begin
        if (accept)
            y_lat <= in_data;
    end

    // History lines: clear in IDLE, shift in y[n] and saturated x[n] on entry to OUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= ORDER; k++) begin
                y_hist[k] <= '0;
                x_hist[k] <= '0;
            end
        end else if (hist_clr) begin
            for (int k = 1; k <= ORDER; k++) begin
                y_hist[k] <= '0;
                x_hist[k] <= '0;
            end
        end else if (load_out) begin
            y_hist[1] <= y_lat;
            x_hist[1] <= res_data;
            for (int k = 2; k <= ORDER; k++) begin
                y_hist[k] <= y_hist[k-1];
                x_hist[k] <= x_hist[k-1];
            end
        end
    end

    // Coefficient bank: identity after reset; writes land only in IDLE, b[0] is fixed at 1.0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_coef[0] <= ONE;
            for (int k = 1; k <= ORDER; k++) begin
                a_coef[k] <= '0;
                b_coef[k] <= '0;
            end
        end else if (coef_wr) begin
            for (int k = 0; k <= ORDER; k++) begin
                if (!coef_sel && (coef_addr == 4'(k)))
                    a_coef[k] <= coef_data;
            end
            for (int k = 1; k <= ORDER; k++) begin
                if (coef_sel && (coef_addr == 4'(k)))
                    b_coef[k] <= coef_data;
            end
        end
    end

    iir_inv_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .acc_clr  (accept),
        .vld_p0   (iss_vld),
        .sub_p0   (iss_sub),
        .smp_p0   (iss_smp),
        .coef_p0  (iss_coef),
        .res_data (res_data),
        .res_sat  (res_sat)
    );

    // ---- accumulator -> output register ----
    // Result register, stable while OUT waits for out_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (load_out) begin
            out_data <= res_data;
            out_sat  <= res_sat;
        end
    end

endmodule

// File: tb/tb_iir_inverse_serial.sv
// Self-checking bench: directed cases plus randomized traffic against a behavioural model.
module tb_iir_inverse_serial;
    import iir_inv_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_sat;
    logic                 coef_we;
    logic                 coef_sel;
    logic        [3:0]    coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 clr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: coefficients and past samples as plain integers
    longint a_m [0:ORDER];
    longint b_m [0:ORDER];
    longint y_m [0:ORDER];
    longint x_m [0:ORDER];

    always #5 clk = ~clk;

    iir_inverse_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .coef_we   (coef_we),
        .coef_sel  (coef_sel),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clr       (clr)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= ORDER; k++) begin
            a_m[k] = 0;
            b_m[k] = 0;
            y_m[k] = 0;
            x_m[k] = 0;
        end
        a_m[0] = 65536;
    endtask

    task automatic model_clr();
        for (int k = 0; k <= ORDER; k++) begin
            y_m[k] = 0;
            x_m[k] = 0;
        end
    endtask

    task automatic model_write(input bit sel, input int addr, input int val);
        if (!sel && addr <= ORDER)
            a_m[addr] = val;
        else if (sel && addr >= 1 && addr <= ORDER)
            b_m[addr] = val;
    endtask

    task automatic model_step(input int y, output longint x, output longint s);
        longint acc;
        longint v;
        for (int k = ORDER; k >= 1; k--) y_m[k] = y_m[k-1];
        y_m[0] = y;
        acc = 0;
        for (int k = 0; k <= ORDER; k++) acc += a_m[k] * y_m[k];
        for (int k = 1; k <= ORDER; k++) acc -= b_m[k] * x_m[k];
        v = acc >>> FRAC;
        s = 0;
        if (v > 64'sd2147483647) begin
            v = 64'sd2147483647;
            s = 1;
        end else if (v < -64'sd2147483648) begin
            v = -64'sd2147483648;
            s = 1;
        end
        x = v;
        for (int k = ORDER; k >= 2; k--) x_m[k] = x_m[k-1];
        x_m[1] = x;
    endtask

    // Sign-extend an 18-bit pattern
    function automatic int sx_coef(input int raw);
        int r;
        r = raw & 32'h3FFFF;
        if (r >= 131072) r -= 262144;
        return r;
    endfunction

    task automatic write_coef(input bit sel, input int addr, input int val);
        coef_we   = 1'b1;
        coef_sel  = sel;
        coef_addr = 4'(addr);
        coef_data = CW'(val);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        model_write(sel, addr, val);
    endtask

    // One sample through the block; starts and ends in IDLE, #1 after a rising edge
    task automatic xfer(input int y, input bit do_clr, input bit do_we, input bit sel,
                        input int addr, input int cval, input int stall, input string tag);
        longint exp_x;
        longint exp_s;
        int     lat;
        bit     seen;
        if (do_clr) model_clr();
        if (do_we) model_write(sel, addr, cval);
        model_step(y, exp_x, exp_s);
        in_data   = y;
        in_valid  = 1'b1;
        clr       = do_clr;
        coef_we   = do_we;
        coef_sel  = sel;
        coef_addr = 4'(addr);
        coef_data = CW'(cval);
        out_ready = (stall == 0);
        @(negedge clk);
        check_val({tag, " in_ready"}, longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        coef_we  = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check_val({tag, " latency"}, lat, 2 * ORDER + 2);
        if (seen) begin
            check_val({tag, " out_data"}, longint'($signed(out_data)), exp_x);
            check_val({tag, " out_sat"}, longint'(out_sat), exp_s);
            for (int i = 0; i < stall; i++) begin
                in_valid  = 1'b1;
                in_data   = ~y;
                coef_we   = 1'b1;
                coef_sel  = 1'b0;
                coef_addr = 4'd0;
                coef_data = '0;
                @(negedge clk);
                check_val({tag, " stall data"}, longint'($signed(out_data)), exp_x);
                check_val({tag, " stall valid"}, longint'(out_valid), 1);
                check_val({tag, " stall in_ready"}, longint'(in_ready), 0);
            end
            in_valid  = 1'b0;
            coef_we   = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check_val({tag, " post valid"}, longint'(out_valid), 0);
            check_val({tag, " post in_ready"}, longint'(in_ready), 1);
        end
    endtask

    task automatic send(input int y, input string tag);
        xfer(y, 1'b0, 1'b0, 1'b0, 0, 0, 0, tag);
    endtask

    initial begin
        int y;
        int stall;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_sel  = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        clr       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset in_ready", longint'(in_ready), 1);
        check_val("reset out_valid", longint'(out_valid), 0);
        check_val("reset out_data", longint'($signed(out_data)), 0);
        check_val("reset out_sat", longint'(out_sat), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Identity pass-through
        send(1234, "ident");

        // FIR zero: a = {1, -0.5}
        write_coef(1'b0, 1, -32768);
        xfer(1000, 1'b1, 1'b0, 1'b0, 0, 0, 0, "fir0");
        send(1000, "fir1");
        send(1000, "fir2");
        write_coef(1'b0, 1, 0);

        // Pole: b1 = -0.5 gives a decaying impulse response
        write_coef(1'b1, 1, -32768);
        xfer(65536, 1'b1, 1'b0, 1'b0, 0, 0, 0, "pole0");
        send(0, "pole1");
        send(0, "pole2");
        send(0, "pole3");
        write_coef(1'b1, 1, 0);

        // Saturation at -2.0 gain, then read the clamped value back through the x history
        write_coef(1'b0, 0, -131072);
        send(32'h7FFFFFFF, "sat");
        write_coef(1'b0, 0, 0);
        write_coef(1'b1, 1, -65536);
        send(5, "xhist");
        write_coef(1'b1, 1, 0);
        write_coef(1'b0, 0, 65536);

        // Ignored writes: b[0] and out-of-range address
        write_coef(1'b1, 0, 12345);
        write_coef(1'b0, 12, 999);
        xfer(4321, 1'b1, 1'b0, 1'b0, 0, 0, 0, "ignored wr");

        // Backpressure for 5 cycles with in_valid and a dropped coefficient write
        xfer(-8765, 1'b0, 1'b0, 1'b0, 0, 0, 5, "stall");
        send(55, "after stall");

        // Write and clear coinciding with the accept
        xfer(3000, 1'b1, 1'b1, 1'b0, 0, 32768, 0, "wr+acc");
        write_coef(1'b0, 0, 65536);

        // Asynchronous reset in the middle of the denominator phase
        write_coef(1'b0, 1, 32768);
        send(600, "pre-rst");
        in_data  = 999;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("async rst out_valid", longint'(out_valid), 0);
        check_val("async rst in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        send(77, "post-rst0");
        send(77, "post-rst1");

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       y = int'($urandom);
                1:       y = int'($urandom_range(0, 2000)) - 1000;
                default: y = int'($urandom_range(0, 200000)) - 100000;
            endcase
            stall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            xfer(y,
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 0) ? sx_coef(int'($urandom)) :
                                               int'($urandom_range(0, 32768)) - 16384,
                 stall,
                 $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
